// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: shared widths, PC step and fetch FSM state encoding.
package fetch_pc_unit_pkg;

    localparam int WIDTH   = 16;
    localparam int PC_STEP = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: control, memory and decode signals of the fetch stage.
interface fetch_pc_unit_if #(
    parameter int WIDTH = fetch_pc_unit_pkg::WIDTH
);

    logic [WIDTH-1:0] NextPC;
    logic             PCWrite;
    logic             Flush;
    logic             IRTake;
    logic             MemAck;
    logic [WIDTH-1:0] MemData;
    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] PCPlus;
    logic             MemReq;
    logic [WIDTH-1:0] MemAddr;
    logic [WIDTH-1:0] IR;
    logic             IRValid;

    modport master (
        input  NextPC, PCWrite, Flush, IRTake, MemAck, MemData,
        output PC, PCPlus, MemReq, MemAddr, IR, IRValid
    );

    modport slave (
        output NextPC, PCWrite, Flush, IRTake, MemAck, MemData,
        input  PC, PCPlus, MemReq, MemAddr, IR, IRValid
    );

endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter plus one-word req/ack instruction fetch into an IR.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int               WIDTH    = fetch_pc_unit_pkg::WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               PC_STEP  = fetch_pc_unit_pkg::PC_STEP
) (
    input logic             CLK,
    input logic             Reset_n,
    fetch_pc_unit_if.master bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] next_pc;

    // Loaded PCs are halfword aligned.
    assign next_pc     = {bus.NextPC[WIDTH-1:1], 1'b0};
    assign bus.PCPlus  = pc_q + WIDTH'(PC_STEP);
    assign bus.PC      = pc_q;
    assign bus.MemAddr = pc_q;
    assign bus.IR      = ir_q;
    assign bus.MemReq  = state_q == REQ;
    assign bus.IRValid = state_q == HOLD;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            REQ: begin
                if (bus.Flush) begin
                    pc_d = next_pc;
                end else if (bus.MemAck) begin
                    ir_d    = bus.MemData;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.Flush) begin
                    pc_d    = next_pc;
                    state_d = REQ;
                end else if (bus.IRTake) begin
                    pc_d    = bus.PCWrite ? next_pc : bus.PCPlus;
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            pc_q    <= {RESET_PC[WIDTH-1:1], 1'b0};
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed scenarios plus random traffic against a behavioural fetch model.
module tb_fetch_pc_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [15:0] m_pc    = 16'h0000;
    logic [15:0] m_ir    = 16'h0000;
    bit          m_valid = 1'b0;
    bit          m_run   = 1'b0;

    fetch_pc_unit_if #(.WIDTH(16)) bus ();

    fetch_pc_unit #(.WIDTH(16), .RESET_PC(16'h0000), .PC_STEP(2)) dut (
        .CLK    (clk),
        .Reset_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input bit f, input bit t, input bit w, input bit a,
                         input logic [15:0] np, input logic [15:0] md);
        bus.Flush   = f;
        bus.IRTake  = t;
        bus.PCWrite = w;
        bus.MemAck  = a;
        bus.NextPC  = np;
        bus.MemData = md;
    endtask

    // Model: a fetch is outstanding whenever the unit is running and holds no word.
    task automatic tick();
        logic [15:0] pc = m_pc;
        logic [15:0] ir = m_ir;
        bit          v  = m_valid;
        bit          r  = m_run;
        if (!rst_n) begin
            pc = 16'h0000; ir = 16'h0000; v = 1'b0; r = 1'b0;
        end else if (!r) begin
            r = 1'b1;
        end else if (bus.Flush) begin
            pc = bus.NextPC & 16'hFFFE; v = 1'b0;
        end else if (!v) begin
            if (bus.MemAck) begin ir = bus.MemData; v = 1'b1; end
        end else if (bus.IRTake) begin
            pc = bus.PCWrite ? (bus.NextPC & 16'hFFFE) : pc + 16'd2;
            v  = 1'b0;
        end
        @(posedge clk);
        #1;
        m_pc = pc; m_ir = ir; m_valid = v; m_run = r;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 16'h0000, 16'h0000);
        repeat (3) tick();
        n_vec++; if (bus.PC !== 16'h0000) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", bus.PC, 16'h0000); end
        n_vec++; if (bus.MemReq !== 1'b0) begin n_err++; $display("FAIL reset_memreq got=%b exp=0", bus.MemReq); end
        n_vec++; if (bus.IRValid !== 1'b0) begin n_err++; $display("FAIL reset_irvalid got=%b exp=0", bus.IRValid); end
        n_vec++; if (bus.IR !== 16'h0000) begin n_err++; $display("FAIL reset_ir got=%h exp=0000", bus.IR); end
    endtask

    task automatic test_first_fetch();
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 16'h0000, 16'hA001);
        tick();
        n_vec++; if (bus.MemReq !== 1'b1) begin n_err++; $display("FAIL first_memreq got=%b exp=1", bus.MemReq); end
        n_vec++; if (bus.MemAddr !== 16'h0000) begin n_err++; $display("FAIL first_addr got=%h exp=0000", bus.MemAddr); end
        tick();
        n_vec++; if (bus.IR !== 16'hA001) begin n_err++; $display("FAIL first_ir got=%h exp=A001", bus.IR); end
        n_vec++; if (bus.IRValid !== 1'b1) begin n_err++; $display("FAIL first_irvalid got=%b exp=1", bus.IRValid); end
        n_vec++; if (bus.MemReq !== 1'b0) begin n_err++; $display("FAIL first_req_drop got=%b exp=0", bus.MemReq); end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            drive(0, 1, 0, 1, 16'h7777, 16'h1000 + 16'(i));
            tick();
            n_vec++; if (bus.MemReq !== 1'b1 || bus.MemAddr !== 16'(2 * i)) begin n_err++; $display("FAIL seq_addr got=%b/%h exp=1/%h", bus.MemReq, bus.MemAddr, 16'(2 * i)); end
            tick();
            n_vec++; if (bus.IRValid !== 1'b1 || bus.IR !== 16'h1000 + 16'(i)) begin n_err++; $display("FAIL seq_ir got=%b/%h exp=1/%h", bus.IRValid, bus.IR, 16'h1000 + 16'(i)); end
        end
    endtask

    task automatic test_stall();
        drive(0, 1, 0, 0, 16'h0000, 16'hDEAD);
        tick();
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (bus.MemReq !== 1'b1 || bus.MemAddr !== 16'h0008 || bus.IRValid !== 1'b0) begin n_err++; $display("FAIL stall_hold got=%b/%h/%b exp=1/0008/0", bus.MemReq, bus.MemAddr, bus.IRValid); end
            if (i < 4) tick();
        end
        drive(0, 0, 0, 1, 16'h0000, 16'h5A5A);
        tick();
        n_vec++; if (bus.IRValid !== 1'b1 || bus.IR !== 16'h5A5A) begin n_err++; $display("FAIL stall_ack got=%b/%h exp=1/5A5A", bus.IRValid, bus.IR); end
    endtask

    task automatic test_pcwrite_hold();
        drive(0, 0, 1, 1, 16'h1235, 16'hCCCC);
        repeat (3) begin
            tick();
            n_vec++; if (bus.PC !== 16'h0008 || bus.IR !== 16'h5A5A || bus.IRValid !== 1'b1) begin n_err++; $display("FAIL hold_stable got=%h/%h/%b exp=0008/5A5A/1", bus.PC, bus.IR, bus.IRValid); end
        end
        drive(0, 1, 1, 0, 16'h1235, 16'hCCCC);
        tick();
        n_vec++; if (bus.PC !== 16'h1234) begin n_err++; $display("FAIL pcwrite_pc got=%h exp=1234", bus.PC); end
        n_vec++; if (bus.MemReq !== 1'b1 || bus.MemAddr !== 16'h1234) begin n_err++; $display("FAIL pcwrite_addr got=%b/%h exp=1/1234", bus.MemReq, bus.MemAddr); end
    endtask

    task automatic test_flush_ack();
        drive(1, 0, 0, 1, 16'h0040, 16'hBEEF);
        tick();
        n_vec++; if (bus.IRValid !== 1'b0 || bus.IR !== 16'h5A5A) begin n_err++; $display("FAIL flush_ir got=%b/%h exp=0/5A5A", bus.IRValid, bus.IR); end
        n_vec++; if (bus.MemReq !== 1'b1 || bus.MemAddr !== 16'h0040) begin n_err++; $display("FAIL flush_addr got=%b/%h exp=1/0040", bus.MemReq, bus.MemAddr); end
    endtask

    task automatic test_wrap();
        drive(1, 0, 0, 0, 16'hFFFF, 16'hBEEF);
        tick();
        n_vec++; if (bus.PC !== 16'hFFFE) begin n_err++; $display("FAIL align_pc got=%h exp=FFFE", bus.PC); end
        n_vec++; if (bus.PCPlus !== 16'h0000) begin n_err++; $display("FAIL wrap_pcplus got=%h exp=0000", bus.PCPlus); end
        drive(0, 0, 0, 1, 16'h0000, 16'hBEEF);
        tick();
        drive(0, 1, 0, 0, 16'h4444, 16'h0000);
        tick();
        n_vec++; if (bus.PC !== 16'h0000 || bus.MemReq !== 1'b1) begin n_err++; $display("FAIL wrap_pc got=%h/%b exp=0000/1", bus.PC, bus.MemReq); end
    endtask

    task automatic test_reset_midop();
        rst_n = 1'b0;
        drive(0, 0, 0, 1, 16'h2222, 16'h1111);
        tick();
        n_vec++; if (bus.MemReq !== 1'b0 || bus.IRValid !== 1'b0) begin n_err++; $display("FAIL midrst_ctrl got=%b/%b exp=0/0", bus.MemReq, bus.IRValid); end
        n_vec++; if (bus.PC !== 16'h0000 || bus.IR !== 16'h0000) begin n_err++; $display("FAIL midrst_regs got=%h/%h exp=0000/0000", bus.PC, bus.IR); end
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 16'h0100, 16'h0000);
        tick();
        n_vec++; if (bus.PC !== 16'h0000 || bus.MemReq !== 1'b1) begin n_err++; $display("FAIL idle_flush got=%h/%b exp=0000/1", bus.PC, bus.MemReq); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, 16'($urandom), 16'($urandom));
            tick();
            n_vec++; if (bus.PC !== m_pc || bus.MemAddr !== m_pc || bus.PCPlus !== m_pc + 16'd2) begin n_err++; $display("FAIL rnd_pc got=%h/%h/%h exp=%h", bus.PC, bus.MemAddr, bus.PCPlus, m_pc); end
            n_vec++; if (bus.MemReq !== (m_run && !m_valid) || bus.IRValid !== m_valid) begin n_err++; $display("FAIL rnd_ctrl got=%b/%b exp=%b/%b", bus.MemReq, bus.IRValid, m_run && !m_valid, m_valid); end
            n_vec++; if (bus.IR !== m_ir) begin n_err++; $display("FAIL rnd_ir got=%h exp=%h", bus.IR, m_ir); end
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_sequential();
        test_stall();
        test_pcwrite_hold();
        test_flush_ack();
        test_wrap();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
